// File: rtl/window3x3_gen.sv
// Streaming 3x3 sliding-window generator over a raster-order pixel stream.
// Two line buffers supply the upper rows of a 3x3 shift-register window.
module window3x3_gen #(
    parameter int WIDTH  = 668,
    parameter int HEIGHT = 452,
    parameter int DW     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DW-1:0]             pix_in,
    input  logic                      pix_valid,
    output logic [9*DW-1:0]           win_out,
    output logic                      win_valid,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic                      frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;

    logic [DW-1:0] lb1 [WIDTH];
    logic [DW-1:0] lb2 [WIDTH];
    logic [DW-1:0] top, mid;
    logic          col_end, row_end, in_win;

    assign top = lb2[col_q];
    assign mid = lb1[col_q];

    always_comb begin
        col_end      = (col_q == COL_LAST);
        row_end      = (row_q == ROW_LAST);
        in_win       = (row_q >= RW'(2)) && (col_q >= CW'(2));
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        if (pix_valid) begin
            col_d = col_end ? '0 : col_q + CW'(1);
            if (col_end) begin
                row_d = row_end ? '0 : row_q + RW'(1);
            end
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2]     = top;
            win_d[5]     = mid;
            win_d[8]     = pix_in;
            win_valid_d  = in_win;
            frame_done_d = row_end && col_end;
            out_row_d    = row_q - RW'(2);
            out_col_d    = col_q - CW'(2);
        end
    end

    // Line buffers are never exposed before being rewritten, so no reset
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb2[col_q] <= lb1[col_q];
            lb1[col_q] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            win_q        <= win_d;
        end
    end

    always_comb begin
        win_out = '0;
        for (int i = 0; i < 9; i++) begin
            win_out[DW*i +: DW] = win_q[i];
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen: a 5x4 instance and a 3x3 instance,
// windows predicted from a stored copy of the current frame.
module tb_window3x3_gen;
    localparam int DW = 8;

    typedef struct {
        int             id;
        logic [9*DW-1:0] win;
        int             row;
        int             col;
        bit             fd;
        longint         due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [DW-1:0]   pin0, pin1;
    logic            pv0, pv1;
    logic [9*DW-1:0] wo0, wo1;
    logic            wv0, wv1, fd0, fd1;
    logic [1:0]      orow0, orow1, ocol1;
    logic [2:0]      ocol0;

    window3x3_gen #(.WIDTH(5), .HEIGHT(4), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pin0), .pix_valid(pv0),
        .win_out(wo0), .win_valid(wv0), .out_row(orow0),
        .out_col(ocol0), .frame_done(fd0)
    );

    window3x3_gen #(.WIDTH(3), .HEIGHT(3), .DW(DW)) dut3 (
        .clk(clk), .rst_n(rst_n), .pix_in(pin1), .pix_valid(pv1),
        .win_out(wo1), .win_valid(wv1), .out_row(orow1),
        .out_col(ocol1), .frame_done(fd1)
    );

    int          checks;
    int          errors;
    longint      cyc = 0;
    exp_t        q[$];
    logic [DW-1:0] frm [2][4][5];
    int          mr[2];
    int          mc[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int id, input logic v, input logic [9*DW-1:0] w,
                       input int r, input int c, input logic fd);
        exp_t e;
        if (!v) begin
            if (fd) begin
                checks++;
                errors++;
                $display("FAIL fd_without_valid id=%0d cyc=%0d got frame_done=1 required 0", id, cyc);
            end
            return;
        end
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_window id=%0d cyc=%0d got win=%h row=%0d col=%0d, required no window",
                     id, cyc, w, r, c);
            return;
        end
        e = q.pop_front();
        if (e.id != id || e.due != cyc || e.win != w || e.row != r ||
            e.col != c || e.fd != fd) begin
            errors++;
            $display("FAIL window id=%0d cyc=%0d got win=%h row=%0d col=%0d fd=%0d, required id=%0d cyc=%0d win=%h row=%0d col=%0d fd=%0d",
                     id, cyc, w, r, c, fd, e.id, e.due, e.win, e.row, e.col, e.fd);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk(0, wv0, wo0, int'(orow0), int'(ocol0), fd0);
            chk(1, wv1, wo1, int'(orow1), int'(ocol1), fd1);
            if (q.size() > 0 && q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_window id=%0d got no win_valid at cyc=%0d, required row=%0d col=%0d",
                         q[0].id, q[0].due, q[0].row, q[0].col);
                void'(q.pop_front());
            end
        end
    end

    task automatic beat(input int id, input bit v, input logic [DW-1:0] p);
        exp_t e;
        int r, c, w, h;
        @(posedge clk);
        #1;
        pv0  = (id == 0) && v;
        pv1  = (id == 1) && v;
        pin0 = p;
        pin1 = p;
        if (!v) return;
        w = (id == 1) ? 3 : 5;
        h = (id == 1) ? 3 : 4;
        r = mr[id];
        c = mc[id];
        frm[id][r][c] = p;
        if (r >= 2 && c >= 2) begin
            e.id  = id;
            e.row = r - 2;
            e.col = c - 2;
            e.fd  = (r == h - 1) && (c == w - 1);
            e.due = cyc + 1;
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[DW*(3*i+j) +: DW] = frm[id][r-2+i][c-2+j];
            q.push_back(e);
        end
        c++;
        if (c == w) begin
            c = 0;
            r++;
            if (r == h) r = 0;
        end
        mr[id] = r;
        mc[id] = c;
    endtask

    // mode 0: base+10*row+col, 1: random, 2: base+WIDTH*row+col
    task automatic frame(input int id, input int base, input int mode, input int gap);
        int w, h;
        logic [DW-1:0] p;
        w = (id == 1) ? 3 : 5;
        h = (id == 1) ? 3 : 4;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                while ($urandom_range(99) < gap) beat(id, 1'b0, '0);
                if (mode == 1) p = DW'($urandom);
                else if (mode == 2) p = DW'(base + w*r + c);
                else p = DW'(base + 10*r + c);
                beat(id, 1'b1, p);
            end
        end
    endtask

    task automatic reset_chk(input string nm);
        checks++;
        if ({wo0, wv0, orow0, ocol0, fd0, wo1, wv1, orow1, ocol1, fd1} != '0) begin
            errors++;
            $display("FAIL %s got win0=%h v0=%b row0=%0d col0=%0d fd0=%b win1=%h v1=%b fd1=%b, required all zero",
                     nm, wo0, wv0, orow0, ocol0, fd0, wo1, wv1, fd1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mr = '{0, 0};
        mc = '{0, 0};
        rst_n = 1'b0;
        pv0 = 1'b0;
        pv1 = 1'b0;
        pin0 = '0;
        pin1 = '0;
        repeat (3) @(posedge clk);
        #2;
        reset_chk("reset_state");
        @(negedge clk) rst_n = 1'b1;

        frame(0, 0, 0, 0);
        frame(0, 0, 0, 40);
        frame(0, 0, 0, 0);
        frame(0, 100, 0, 0);
        repeat (3) frame(0, 0, 1, 30);

        for (int k = 0; k < 7; k++) beat(0, 1'b1, DW'(50 + k));
        beat(0, 1'b0, '0);
        #3 rst_n = 1'b0;
        #1 reset_chk("async_reset");
        q.delete();
        mr[0] = 0;
        mc[0] = 0;
        @(negedge clk) rst_n = 1'b1;
        frame(0, 0, 0, 0);

        frame(1, 0, 2, 0);
        frame(1, 0, 1, 30);
        repeat (4) beat(0, 1'b0, '0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending windows, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
